// File: rtl/wei_pec_dispatch_pkg.sv
// Shared block geometry and dispatcher FSM state encodings.
// Module-level parameters default to these values.
package wei_pec_dispatch_pkg;

    localparam int NUM_PEC     = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int BLOCK_DEPTH = 32;
    localparam int KERNEL_SIZE = 9;
    localparam int CNT_W       = 10;

    localparam int WEI_BLK_W = DATA_WIDTH * BLOCK_DEPTH * KERNEL_SIZE;
    localparam int FLG_BLK_W = BLOCK_DEPTH * KERNEL_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_POP   = 3'd2,
        ST_LATCH = 3'd3,
        ST_OFFER = 3'd4,
        ST_DONE  = 3'd5
    } wpd_state_t;

endpackage

// File: rtl/wei_pec_dispatch_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Zero latency; the pointer is owned and advanced by the parent.
module wei_pec_dispatch_rr_arbiter #(
    parameter int NUM_PEC = 4,
    parameter int PW      = (NUM_PEC > 1) ? $clog2(NUM_PEC) : 1
) (
    input  logic [NUM_PEC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               gnt_vld,
    output logic [NUM_PEC-1:0] gnt_oh,
    output logic [PW-1:0]      gnt_idx
);

    localparam int SW = PW + 1;

    logic [SW-1:0] pos;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        pos     = '0;
        for (int i = 0; i < NUM_PEC; i++) begin
            // ptr < NUM_PEC and i < NUM_PEC, so one subtraction wraps correctly
            pos = {1'b0, ptr} + SW'(i);
            if (pos >= SW'(NUM_PEC)) begin
                pos = pos - SW'(NUM_PEC);
            end
            if (!gnt_vld && req[pos[PW-1:0]]) begin
                gnt_vld                = 1'b1;
                gnt_oh[pos[PW-1:0]]    = 1'b1;
                gnt_idx                = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/wei_pec_dispatch.sv
// Pops one weight block per PEC request, latches it and offers it to the round-robin
// grantee over valid/ack; request-to-valid is 3 cycles, valid holds until the grantee acks.
module wei_pec_dispatch #(
    parameter int NUM_PEC     = wei_pec_dispatch_pkg::NUM_PEC,
    parameter int DATA_WIDTH  = wei_pec_dispatch_pkg::DATA_WIDTH,
    parameter int BLOCK_DEPTH = wei_pec_dispatch_pkg::BLOCK_DEPTH,
    parameter int KERNEL_SIZE = wei_pec_dispatch_pkg::KERNEL_SIZE,
    parameter int CNT_W       = wei_pec_dispatch_pkg::CNT_W
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        CTRLACT_FnhFrm,
    input  logic [CNT_W-1:0]                            CFG_NumBlk,
    input  logic                                        DISWEI_RdyFIFO,
    output logic                                        CTRLWEI_PlsFetch,
    input  logic [DATA_WIDTH*BLOCK_DEPTH*KERNEL_SIZE-1:0] DISWEIPEC_Wei,
    input  logic [BLOCK_DEPTH*KERNEL_SIZE-1:0]          DISWEIPEC_FlgWei,
    input  logic [NUM_PEC-1:0]                          PEC_ReqWei,
    output logic [NUM_PEC-1:0]                          PEC_ValWei,
    input  logic [NUM_PEC-1:0]                          PEC_AckWei,
    output logic [DATA_WIDTH*BLOCK_DEPTH*KERNEL_SIZE-1:0] PEC_Wei,
    output logic [BLOCK_DEPTH*KERNEL_SIZE-1:0]          PEC_FlgWei,
    output logic                                        CTRLWEI_FnhFrm,
    output logic                                        CTRLWEI_Busy
);

    import wei_pec_dispatch_pkg::*;

    localparam int PW = (NUM_PEC > 1) ? $clog2(NUM_PEC) : 1;

    wpd_state_t         state;
    logic [CNT_W-1:0]   blk_cnt;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant;
    logic [NUM_PEC-1:0] grant_oh;

    logic               arb_vld;
    logic [NUM_PEC-1:0] arb_oh;
    logic [PW-1:0]      arb_idx;
    logic               frame_full;

    wei_pec_dispatch_rr_arbiter #(
        .NUM_PEC (NUM_PEC),
        .PW      (PW)
    ) u_rr_arbiter (
        .req     (PEC_ReqWei),
        .ptr     (rr_ptr),
        .gnt_vld (arb_vld),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    assign frame_full = (CFG_NumBlk != '0) && (blk_cnt == CFG_NumBlk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            blk_cnt    <= '0;
            rr_ptr     <= '0;
            grant      <= '0;
            grant_oh   <= '0;
            PEC_Wei    <= '0;
            PEC_FlgWei <= '0;
        end else if (CTRLACT_FnhFrm) begin
            // frame abort wins over every transition; the data registers keep their contents
            state    <= ST_IDLE;
            blk_cnt  <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            grant_oh <= '0;
        end else begin
            unique case (state)
                ST_IDLE: state <= ST_ARB;
                ST_ARB: begin
                    if (frame_full) begin
                        state <= ST_DONE;
                    end else if (DISWEI_RdyFIFO && arb_vld) begin
                        grant    <= arb_idx;
                        grant_oh <= arb_oh;
                        state    <= ST_POP;
                    end
                end
                ST_POP: state <= ST_LATCH;
                ST_LATCH: begin
                    PEC_Wei    <= DISWEIPEC_Wei;
                    PEC_FlgWei <= DISWEIPEC_FlgWei;
                    state      <= ST_OFFER;
                end
                ST_OFFER: begin
                    if (PEC_AckWei[grant]) begin
                        if (blk_cnt != '1) begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                        rr_ptr <= (grant == PW'(NUM_PEC - 1)) ? '0 : grant + 1'b1;
                        state  <= ST_ARB;
                    end
                end
                ST_DONE: begin
                    blk_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A pop already committed in POP still goes out on abort: the FIFO is flushed by the same pulse.
    assign CTRLWEI_PlsFetch = (state == ST_POP);
    assign CTRLWEI_FnhFrm   = (state == ST_DONE) && !CTRLACT_FnhFrm;
    assign PEC_ValWei       = ((state == ST_OFFER) && !CTRLACT_FnhFrm) ? grant_oh : '0;
    assign CTRLWEI_Busy     = (state != ST_IDLE) && (state != ST_ARB);

endmodule

// File: tb/tb_wei_pec_dispatch.sv
// Directed bench for wei_pec_dispatch: fetch/offer timing, round-robin, frame end, abort.
module tb_wei_pec_dispatch;

    import wei_pec_dispatch_pkg::*;

    localparam int NP    = 4;
    localparam int WEI_W = 8 * 32 * 9;
    localparam int FLG_W = 32 * 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             CTRLACT_FnhFrm;
    logic [9:0]       CFG_NumBlk;
    logic             DISWEI_RdyFIFO;
    logic             CTRLWEI_PlsFetch;
    logic [WEI_W-1:0] DISWEIPEC_Wei;
    logic [FLG_W-1:0] DISWEIPEC_FlgWei;
    logic [NP-1:0]    PEC_ReqWei;
    logic [NP-1:0]    PEC_ValWei;
    logic [NP-1:0]    PEC_AckWei;
    logic [WEI_W-1:0] PEC_Wei;
    logic [FLG_W-1:0] PEC_FlgWei;
    logic             CTRLWEI_FnhFrm;
    logic             CTRLWEI_Busy;

    logic [WEI_W-1:0] wei_a5;
    logic [WEI_W-1:0] wei_3c;
    logic [FLG_W-1:0] flg_a;
    logic [FLG_W-1:0] flg_b;

    int checks = 0;
    int passed = 0;
    int fetch_cnt = 0;
    int fnh_cnt = 0;
    int base;

    wei_pec_dispatch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .CTRLACT_FnhFrm   (CTRLACT_FnhFrm),
        .CFG_NumBlk       (CFG_NumBlk),
        .DISWEI_RdyFIFO   (DISWEI_RdyFIFO),
        .CTRLWEI_PlsFetch (CTRLWEI_PlsFetch),
        .DISWEIPEC_Wei    (DISWEIPEC_Wei),
        .DISWEIPEC_FlgWei (DISWEIPEC_FlgWei),
        .PEC_ReqWei       (PEC_ReqWei),
        .PEC_ValWei       (PEC_ValWei),
        .PEC_AckWei       (PEC_AckWei),
        .PEC_Wei          (PEC_Wei),
        .PEC_FlgWei       (PEC_FlgWei),
        .CTRLWEI_FnhFrm   (CTRLWEI_FnhFrm),
        .CTRLWEI_Busy     (CTRLWEI_Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (CTRLWEI_PlsFetch) fetch_cnt <= fetch_cnt + 1;
        if (CTRLWEI_FnhFrm)   fnh_cnt   <= fnh_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (ok) passed++;
        else $error("FAIL %s", tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic serve(input string tag, input int idx);
        step(1);
        chk({tag, "_fetch"}, CTRLWEI_PlsFetch === 1'b1);
        step(2);
        chk({tag, "_val"}, PEC_ValWei === (4'b0001 << idx));
        step(1);
        chk({tag, "_arb"}, dut.state === ST_ARB);
    endtask

    initial begin
        wei_a5 = {288{8'hA5}};
        wei_3c = {288{8'h3C}};
        flg_a  = {144{2'b10}};
        flg_b  = {144{2'b01}};

        rst_n            = 1'b0;
        CTRLACT_FnhFrm   = 1'b0;
        CFG_NumBlk       = '0;
        DISWEI_RdyFIFO   = 1'b0;
        DISWEIPEC_Wei    = '0;
        DISWEIPEC_FlgWei = '0;
        PEC_ReqWei       = '0;
        PEC_AckWei       = '0;

        step(3);
        chk("rst_state", dut.state === ST_IDLE);
        chk("rst_val", PEC_ValWei === 4'b0000);
        chk("rst_fetch", CTRLWEI_PlsFetch === 1'b0);
        chk("rst_fnh", CTRLWEI_FnhFrm === 1'b0);
        chk("rst_busy", CTRLWEI_Busy === 1'b0);
        chk("rst_cnt", dut.blk_cnt === 10'd0);
        chk("rst_wei", PEC_Wei === '0);
        rst_n = 1'b1;
        step(2);
        chk("idle_to_arb", dut.state === ST_ARB);

        DISWEI_RdyFIFO   = 1'b1;
        PEC_ReqWei       = 4'b0001;
        DISWEIPEC_Wei    = wei_a5;
        DISWEIPEC_FlgWei = flg_a;
        step(1);
        chk("t1_fetch", CTRLWEI_PlsFetch === 1'b1);
        chk("t1_busy", CTRLWEI_Busy === 1'b1);
        step(1);
        chk("t1_fetch_once", CTRLWEI_PlsFetch === 1'b0);
        chk("t1_val_early", PEC_ValWei === 4'b0000);
        step(1);
        chk("t1_val", PEC_ValWei === 4'b0001);
        chk("t1_wei", PEC_Wei === wei_a5);
        chk("t1_flg", PEC_FlgWei === flg_a);
        step(1);
        chk("t1_val_hold1", PEC_ValWei === 4'b0001);
        step(1);
        chk("t1_val_hold2", PEC_ValWei === 4'b0001);
        PEC_AckWei = 4'b0001;
        step(1);
        chk("t1_val_drop", PEC_ValWei === 4'b0000);
        chk("t1_cnt", dut.blk_cnt === 10'd1);
        chk("t1_ptr", dut.rr_ptr === 2'd1);
        chk("t1_fetch_total", fetch_cnt == 1);
        PEC_ReqWei = '0;
        PEC_AckWei = '0;

        step(1);
        CTRLACT_FnhFrm = 1'b1;
        step(1);
        CTRLACT_FnhFrm = 1'b0;
        chk("ab0_state", dut.state === ST_IDLE);
        chk("ab0_ptr", dut.rr_ptr === 2'd0);
        chk("ab0_cnt", dut.blk_cnt === 10'd0);

        PEC_ReqWei = 4'b1111;
        PEC_AckWei = 4'b1111;
        step(1);
        base = fetch_cnt;
        for (int k = 0; k < 5; k++) serve("rr", k % 4);
        PEC_ReqWei = '0;
        PEC_AckWei = '0;
        chk("rr_fetches", (fetch_cnt - base) == 5);
        chk("rr_cnt", dut.blk_cnt === 10'd5);
        chk("rr_ptr", dut.rr_ptr === 2'd1);

        PEC_ReqWei     = 4'b0010;
        DISWEI_RdyFIFO = 1'b0;
        base = fetch_cnt;
        step(10);
        chk("empty_nofetch", (fetch_cnt - base) == 0);
        chk("empty_arb", dut.state === ST_ARB);
        DISWEI_RdyFIFO = 1'b1;
        step(1);
        chk("empty_fetch", CTRLWEI_PlsFetch === 1'b1);
        step(2);
        chk("empty_val", PEC_ValWei === 4'b0010);

        PEC_AckWei = 4'b0001;
        PEC_ReqWei = 4'b0000;
        step(1);
        chk("ign_val1", PEC_ValWei === 4'b0010);
        chk("ign_cnt1", dut.blk_cnt === 10'd5);
        PEC_AckWei = 4'b0000;
        step(1);
        chk("ign_val2", PEC_ValWei === 4'b0010);
        PEC_AckWei = 4'b0010;
        step(1);
        chk("ign_done_val", PEC_ValWei === 4'b0000);
        chk("ign_cnt2", dut.blk_cnt === 10'd6);
        chk("ign_ptr", dut.rr_ptr === 2'd2);
        PEC_AckWei = 4'b0000;

        PEC_ReqWei = 4'b0100;
        step(1);
        chk("ab_fetch", CTRLWEI_PlsFetch === 1'b1);
        PEC_ReqWei = 4'b0000;
        step(2);
        chk("ab_val", PEC_ValWei === 4'b0100);
        CTRLACT_FnhFrm = 1'b1;
        step(1);
        CTRLACT_FnhFrm = 1'b0;
        chk("ab_val_clr", PEC_ValWei === 4'b0000);
        chk("ab_state", dut.state === ST_IDLE);
        chk("ab_cnt", dut.blk_cnt === 10'd0);
        chk("ab_ptr", dut.rr_ptr === 2'd0);
        chk("ab_busy", CTRLWEI_Busy === 1'b0);
        chk("ab_wei_kept", PEC_Wei === wei_a5);
        PEC_AckWei = 4'b0100;
        step(1);
        chk("ab_late_state", dut.state === ST_ARB);
        chk("ab_late_cnt", dut.blk_cnt === 10'd0);
        PEC_AckWei = 4'b0000;
        step(1);
        chk("ab_late_cnt2", dut.blk_cnt === 10'd0);

        CFG_NumBlk       = 10'd3;
        DISWEIPEC_Wei    = wei_3c;
        DISWEIPEC_FlgWei = flg_b;
        PEC_ReqWei       = 4'b1111;
        PEC_AckWei       = 4'b1111;
        base = fetch_cnt;
        serve("fr", 0);
        chk("fr_wei", PEC_Wei === wei_3c);
        chk("fr_flg", PEC_FlgWei === flg_b);
        serve("fr", 1);
        serve("fr", 2);
        chk("fr_cnt3", dut.blk_cnt === 10'd3);
        chk("fr_fnh_early", CTRLWEI_FnhFrm === 1'b0);
        step(1);
        chk("fr_fnh", CTRLWEI_FnhFrm === 1'b1);
        chk("fr_no4th", CTRLWEI_PlsFetch === 1'b0);
        chk("fr_busy", CTRLWEI_Busy === 1'b1);
        PEC_ReqWei = '0;
        PEC_AckWei = '0;
        step(1);
        chk("fr_fnh_once", CTRLWEI_FnhFrm === 1'b0);
        chk("fr_cnt0", dut.blk_cnt === 10'd0);
        chk("fr_state", dut.state === ST_IDLE);
        step(2);
        chk("fr_fetches", (fetch_cnt - base) == 3);
        chk("fr_fnh_cnt", fnh_cnt == 1);

        CFG_NumBlk = 10'd0;
        PEC_ReqWei = 4'b1111;
        PEC_AckWei = 4'b1111;
        base = fetch_cnt;
        step(4 * 1030);
        chk("sat_fetches", (fetch_cnt - base) == 1030);
        chk("sat_cnt", dut.blk_cnt === 10'h3FF);
        chk("sat_fnh", fnh_cnt == 1);
        PEC_ReqWei = '0;
        PEC_AckWei = '0;
        step(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
